// File: rtl/mul_cell_arbiter_if.sv
// Bundle between the multiply-cell arbiter, its two requesters, the response consumer
// and the shared multiply cell. The slave side is the arbiter; master is everything around it.
interface mul_cell_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_src1;
  logic [2*DATA_W-1:0] req_src2;
  logic [1:0]          req_signed1;
  logic [1:0]          req_signed2;
  logic [1:0]          req_hi;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_data;

  logic [DATA_W-1:0]   cell_src1;
  logic [DATA_W-1:0]   cell_src2;
  logic                cell_signa;
  logic                cell_signb;
  logic                cell_in_en;
  logic                cell_out_en;
  logic                cell_shift_right;
  logic                cell_rotate;
  logic                cell_aclr;
  logic [DATA_W-1:0]   cell_result;

  modport master (
    output req_valid, req_src1, req_src2, req_signed1, req_signed2, req_hi,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  cell_src1, cell_src2, cell_signa, cell_signb, cell_in_en, cell_out_en,
    input  cell_shift_right, cell_rotate, cell_aclr,
    output cell_result
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_signed1, req_signed2, req_hi,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output cell_src1, cell_src2, cell_signa, cell_signb, cell_in_en, cell_out_en,
    output cell_shift_right, cell_rotate, cell_aclr,
    input  cell_result
  );
endinterface

// File: rtl/mul_cell_arbiter.sv
// Round-robin share of one two-stage multiply cell between two requesters; 2-cycle latency,
// one op/cycle. A stalled response freezes both cell banks and blocks new requests.
module mul_cell_arbiter #(
  parameter int   DATA_W     = 32,
  parameter logic RESET_PRIO = 1'b0
) (
  input logic               clk,
  input logic               reset,
  mul_cell_arbiter_if.slave bus
);
  logic       adv;
  logic [1:0] grant;
  logic       gsel;
  logic       prio;
  logic       s1_valid;
  logic       s1_id;
  logic       s1_hi;
  logic       s2_valid;
  logic       s2_id;

  assign adv = !(s2_valid && !bus.rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (adv) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // With no grant gsel falls to requester 0; the cell inputs are then don't-care.
  assign gsel = grant[1];

  assign bus.req_ready        = grant;
  assign bus.cell_src1        = gsel ? bus.req_src1[2*DATA_W-1:DATA_W] : bus.req_src1[DATA_W-1:0];
  assign bus.cell_src2        = gsel ? bus.req_src2[2*DATA_W-1:DATA_W] : bus.req_src2[DATA_W-1:0];
  assign bus.cell_signa       = bus.req_signed1[gsel];
  assign bus.cell_signb       = bus.req_signed2[gsel];
  assign bus.cell_in_en       = adv;
  assign bus.cell_out_en      = adv;
  // The cell applies shift_right when loading its output register, i.e. while the op sits in S1.
  assign bus.cell_shift_right = s1_hi;
  assign bus.cell_rotate      = 1'b0;
  assign bus.cell_aclr        = reset;

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_data  = bus.cell_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_hi    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      prio     <= RESET_PRIO;
    end else if (adv) begin
      s1_valid <= |grant;
      s1_id    <= gsel;
      s1_hi    <= bus.req_hi[gsel];
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      // Only a contested grant hands priority over; a lone requester leaves it alone.
      if (&bus.req_valid) begin
        prio <= ~gsel;
      end
    end
  end
endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Directed and random checks of mul_cell_arbiter against an issue-order scoreboard,
// with a behavioural model of the multiply cell attached to its cell ports.
module tb_mul_cell_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_cell_arbiter_if #(.DATA_W(W)) bus ();

  mul_cell_arbiter #(.DATA_W(W), .RESET_PRIO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiply cell: registered inputs, registered output, both with enables and clear.
  logic [W-1:0] ca, cb, cres;
  logic         csa, csb;
  logic signed [2*W+1:0] cprod;
  assign cprod = $signed({csa & ca[W-1], ca}) * $signed({csb & cb[W-1], cb});
  always @(posedge clk) begin
    if (bus.cell_aclr) begin
      ca <= '0; cb <= '0; csa <= 1'b0; csb <= 1'b0; cres <= '0;
    end else begin
      if (bus.cell_in_en) begin
        ca <= bus.cell_src1; cb <= bus.cell_src2;
        csa <= bus.cell_signa; csb <= bus.cell_signb;
      end
      if (bus.cell_out_en) cres <= bus.cell_shift_right ? cprod[2*W-1:W] : cprod[W-1:0];
    end
  end
  assign bus.cell_result = cres;

  // Reference: extend each operand to 64 bits by its signedness; the low 64 bits are exact.
  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sa, input logic sb, input logic hi);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[W-1]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[W-1]}}, b} : {32'h0, b};
    p  = ea * eb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           age;   // 0 = issued last cycle, 1 = visible on the response port
  } ent_t;

  ent_t        pipe[$];
  logic        prio_m;
  int          checks, errors;
  logic [1:0]  last_g;
  logic        obs_rv, obs_id;
  logic [W-1:0] obs_data;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb, input logic hi);
    bus.req_src1[id*W +: W] = a;
    bus.req_src2[id*W +: W] = b;
    bus.req_signed1[id]     = sa;
    bus.req_signed2[id]     = sb;
    bus.req_hi[id]          = hi;
  endtask

  // One clock: check the DUT at the negedge against the model, then advance the model.
  task automatic tick();
    logic       exp_rv, stall, win;
    logic [1:0] g;
    ent_t       e;
    @(negedge clk);
    exp_rv = (pipe.size() > 0) && (pipe[0].age == 1);
    stall  = exp_rv && !bus.rsp_ready;
    g      = 2'b00;
    win    = 1'b0;
    if (!stall && bus.req_valid != 2'b00) begin
      win = (&bus.req_valid) ? prio_m : bus.req_valid[1];
      g   = win ? 2'b10 : 2'b01;
    end
    last_g   = bus.req_ready;
    obs_rv   = bus.rsp_valid;
    obs_id   = bus.rsp_id;
    obs_data = bus.rsp_data;
    chk("req_ready", {30'h0, bus.req_ready}, {30'h0, g});
    chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, exp_rv});
    chk("cell_aclr", {31'h0, bus.cell_aclr}, {31'h0, reset});
    if (exp_rv) begin
      chk("rsp_id", {31'h0, bus.rsp_id}, {31'h0, pipe[0].id});
      chk("rsp_data", bus.rsp_data, pipe[0].data);
    end
    if (reset) begin
      pipe.delete();
      prio_m = 1'b0;
    end else if (!stall) begin
      if (exp_rv) void'(pipe.pop_front());
      foreach (pipe[i]) pipe[i].age = 1;
      if (g != 2'b00) begin
        e.id   = win;
        e.data = ref_prod(win ? bus.req_src1[2*W-1:W] : bus.req_src1[W-1:0],
                          win ? bus.req_src2[2*W-1:W] : bus.req_src2[W-1:0],
                          bus.req_signed1[win], bus.req_signed2[win], bus.req_hi[win]);
        e.age  = 0;
        pipe.push_back(e);
        if (&bus.req_valid) prio_m = ~win;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; prio_m = 1'b0;
    reset = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    bus.req_src1 = '0; bus.req_src2 = '0;
    bus.req_signed1 = '0; bus.req_signed2 = '0; bus.req_hi = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with both requesters raised to see the arbitration output.
    bus.req_valid = 2'b11;
    #1;
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_id", {31'h0, bus.rsp_id}, 32'h0);
    chk("rst_req_ready", {30'h0, bus.req_ready}, 32'h1);
    chk("rst_cell_aclr", {31'h0, bus.cell_aclr}, 32'h1);
    chk("cell_rotate", {31'h0, bus.cell_rotate}, 32'h0);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // Single op 3x5.
    set_op(0, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    tick();
    chk("single_ready", {30'h0, last_g}, 32'h1);
    bus.req_valid = 2'b00;
    tick();
    tick();
    chk("single_valid", {31'h0, obs_rv}, 32'h1);
    chk("single_id", {31'h0, obs_id}, 32'h0);
    chk("single_data", obs_data, 32'h0000000F);

    // Sign / high-half selection, back to back from requester 0.
    bus.req_valid = 2'b01;
    set_op(0, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b1, 1'b0); tick();
    set_op(0, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b1, 1'b1); tick();
    set_op(0, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0, 1'b1); tick();
    chk("signed_lo", obs_data, 32'hFFFFFFFE);
    bus.req_valid = 2'b00;
    tick();
    chk("signed_hi", obs_data, 32'hFFFFFFFF);
    tick();
    chk("unsigned_hi", obs_data, 32'h00000001);

    // Round robin: both valid for six cycles.
    set_op(0, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
    set_op(1, 32'd17, 32'd19, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = (i < 6) ? 2'b11 : 2'b00;
      tick();
      if (i < 6) chk("rr_grant", {30'h0, last_g}, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i >= 2) chk("rr_rsp_id", {31'h0, obs_id}, ((i - 2) % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Backpressure with both stages full.
    bus.req_valid = 2'b01;
    set_op(0, 32'h1234, 32'h10, 1'b0, 1'b0, 1'b0); tick();
    set_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0); tick();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_req_ready", {30'h0, last_g}, 32'h0);
      chk("bp_data_held", obs_data, 32'h00012340);
      chk("bp_id_held", {31'h0, obs_id}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    chk("bp_drain0", obs_data, 32'h00012340);
    tick();
    chk("bp_drain1_valid", {31'h0, obs_rv}, 32'h1);
    chk("bp_drain1", obs_data, 32'h00000001);
    tick();
    chk("bp_empty", {31'h0, obs_rv}, 32'h0);

    // Lone requester 1 must not take priority from requester 0.
    bus.req_valid = 2'b10;
    repeat (3) tick();
    bus.req_valid = 2'b11;
    tick();
    chk("lone_then_both", {30'h0, last_g}, 32'h1);
    bus.req_valid = 2'b00;
    repeat (2) tick();

    // Reset one cycle after a handshake drops the op.
    set_op(1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_drop", {31'h0, obs_rv}, 32'h0);
    end
    set_op(1, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    chk("post_rst_valid", {31'h0, obs_rv}, 32'h1);
    chk("post_rst_id", {31'h0, obs_id}, 32'h1);
    chk("post_rst_data", obs_data, 32'h0000002A);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid   = 2'($urandom_range(0, 3));
      bus.rsp_ready   = ($urandom_range(0, 3) != 0);
      bus.req_src1    = {$urandom, $urandom};
      bus.req_src2    = {$urandom, $urandom};
      bus.req_signed1 = 2'($urandom_range(0, 3));
      bus.req_signed2 = 2'($urandom_range(0, 3));
      bus.req_hi      = 2'($urandom_range(0, 3));
      reset           = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    chk("final_empty", {31'h0, obs_rv}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
